// File: rtl/lb_ctl_pkg.sv
// lb_ctl_pkg: shared state encoding for the loopback controller
package lb_ctl_pkg;
  typedef enum logic [1:0] {
    NORM      = 2'd0,
    WAIT_LB   = 2'd1,
    LB        = 2'd2,
    WAIT_NORM = 2'd3
  } lb_state_t;
endpackage

// File: rtl/debouncer.sv
// debouncer: 2-flop synchroniser plus a run-length filter that only follows a stable input
module debouncer #(
  parameter int FILTER = 200_000
) (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic filt
);
  localparam int W = $clog2(FILTER + 1);
  localparam logic [W-1:0] LAST = W'(FILTER - 1);
  logic meta, sync;
  logic [W-1:0] cnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      sync <= 1'b0;
      cnt  <= '0;
      filt <= 1'b0;
    end else begin
      meta <= sig;
      sync <= meta;
      cnt  <= (sync == filt || cnt == LAST) ? '0 : cnt + 1'b1;
      filt <= (sync != filt && cnt == LAST) ? sync : filt;
    end
  end
endmodule

// File: rtl/lb_ch_ctl.sv
// lb_ch_ctl: one loopback channel that only swaps the pin mux while both lines are idle
module lb_ch_ctl
  import lb_ctl_pkg::*;
#(
  parameter int FILTER      = 200_000,
  parameter int IDLE_CYCLES = 4340
) (
  input  logic clk,
  input  logic rst,
  input  logic lb_sel,
  input  logic txd_tx,
  input  logic rxd,
  output logic txd,
  output logic lb_active,
  output logic lb_chg
);
  localparam int W = $clog2(IDLE_CYCLES + 1);
  localparam logic [W-1:0] IDLE_MAX = W'(IDLE_CYCLES);
  lb_state_t state, state_nxt;
  logic sel_filt, rxd_m, rxd_s, idle;
  logic [W-1:0] idle_cnt;
  debouncer #(.FILTER(FILTER)) u_deb (
    .clk (clk),
    .rst (rst),
    .sig (lb_sel),
    .filt(sel_filt)
  );
  assign idle = idle_cnt == IDLE_MAX;
  assign txd  = lb_active ? rxd : txd_tx;
  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_m     <= 1'b1;
      rxd_s     <= 1'b1;
      idle_cnt  <= '0;
      state     <= NORM;
      lb_active <= 1'b0;
      lb_chg    <= 1'b0;
    end else begin
      rxd_m     <= rxd;
      rxd_s     <= rxd_m;
      idle_cnt  <= (!txd_tx || !rxd_s) ? '0 : idle ? idle_cnt : idle_cnt + 1'b1;
      state     <= state_nxt;
      lb_active <= state_nxt == LB || state_nxt == WAIT_NORM;
      lb_chg    <= (state == WAIT_LB && state_nxt == LB) || (state == WAIT_NORM && state_nxt == NORM);
    end
  end
  always_comb begin
    state_nxt = state;
    case (state)
      NORM:    state_nxt = sel_filt ? WAIT_LB : NORM;
      WAIT_LB: state_nxt = !sel_filt ? NORM : idle ? LB : WAIT_LB;
      LB:      state_nxt = sel_filt ? LB : WAIT_NORM;
      default: state_nxt = sel_filt ? LB : idle ? NORM : WAIT_NORM;
    endcase
  end
endmodule

// File: rtl/lb_ctl_mc.sv
// lb_ctl_mc: independent idle-gated loopback controllers, one per UART channel
module lb_ctl_mc #(
  parameter int NUM_CH      = 2,
  parameter int FILTER      = 200_000,
  parameter int IDLE_CYCLES = 4340
) (
  input  logic              clk_tx,
  input  logic              rst_clk_tx,
  input  logic [NUM_CH-1:0] lb_sel_i,
  input  logic [NUM_CH-1:0] txd_tx,
  input  logic [NUM_CH-1:0] rxd_i,
  output logic [NUM_CH-1:0] txd_o,
  output logic [NUM_CH-1:0] lb_active_o,
  output logic [NUM_CH-1:0] lb_chg_o
);
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    lb_ch_ctl #(.FILTER(FILTER), .IDLE_CYCLES(IDLE_CYCLES)) u_ch (
      .clk      (clk_tx),
      .rst      (rst_clk_tx),
      .lb_sel   (lb_sel_i[i]),
      .txd_tx   (txd_tx[i]),
      .rxd      (rxd_i[i]),
      .txd      (txd_o[i]),
      .lb_active(lb_active_o[i]),
      .lb_chg   (lb_chg_o[i])
    );
  end
endmodule

// File: tb/tb_lb_ctl_mc.sv
// tb_lb_ctl_mc: table vectors, corner sequences and a random run against a behavioural model
module tb_lb_ctl_mc;
  localparam int FILTER = 8;
  localparam int IDLE = 4;
  logic clk_tx = 1'b0;
  logic rst_clk_tx;
  logic [1:0] lb_sel_i, txd_tx, rxd_i, txd_o, lb_active_o, lb_chg_o;
  int checks = 0;
  int errors = 0;
  lb_ctl_mc #(.NUM_CH(2), .FILTER(FILTER), .IDLE_CYCLES(IDLE)) dut (
    .clk_tx     (clk_tx),
    .rst_clk_tx (rst_clk_tx),
    .lb_sel_i   (lb_sel_i),
    .txd_tx     (txd_tx),
    .rxd_i      (rxd_i),
    .txd_o      (txd_o),
    .lb_active_o(lb_active_o),
    .lb_chg_o   (lb_chg_o)
  );
  always #5 clk_tx = ~clk_tx;
  bit s1[2], s2[2], filt[2], r1[2], r2[2], pend[2];
  int drun[2], irun[2];
  logic [1:0] m_act, m_chg;
  task automatic chk(input string name, input logic [1:0] got, input logic [1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, got, exp);
    end
  endtask
  task automatic model_step();
    for (int c = 0; c < 2; c++) begin
      if (rst_clk_tx) begin
        s1[c] = 0; s2[c] = 0; filt[c] = 0; drun[c] = 0;
        r1[c] = 1; r2[c] = 1; irun[c] = 0; pend[c] = 0;
        m_act[c] = 0; m_chg[c] = 0;
      end else begin
        m_chg[c] = 0;
        if (pend[c]) begin
          if (filt[c] == m_act[c]) pend[c] = 0;
          else if (irun[c] >= IDLE) begin
            m_act[c] = ~m_act[c];
            pend[c] = 0;
            m_chg[c] = 1;
          end
        end else if (filt[c] != m_act[c]) pend[c] = 1;
        if (s2[c] == filt[c]) drun[c] = 0;
        else begin
          drun[c]++;
          if (drun[c] == FILTER) begin
            filt[c] = s2[c];
            drun[c] = 0;
          end
        end
        irun[c] = (txd_tx[c] && r2[c]) ? ((irun[c] + 1 > IDLE) ? IDLE : irun[c] + 1) : 0;
        s2[c] = s1[c]; s1[c] = lb_sel_i[c];
        r2[c] = r1[c]; r1[c] = rxd_i[c];
      end
    end
  endtask
  task automatic tick();
    logic [1:0] exp_txo;
    @(posedge clk_tx);
    model_step();
    @(negedge clk_tx);
    for (int c = 0; c < 2; c++) exp_txo[c] = m_act[c] ? rxd_i[c] : txd_tx[c];
    chk("model_active", lb_active_o, m_act);
    chk("model_chg", lb_chg_o, m_chg);
    chk("model_txd", txd_o, exp_txo);
  endtask
  task automatic do_reset();
    rst_clk_tx = 1'b1;
    tick();
    tick();
    rst_clk_tx = 1'b0;
  endtask
  typedef struct {
    int n;
    logic rst;
    logic [1:0] sel, txd, rxd, act, chg, txo;
  } vec_t;
  vec_t tbl[6];
  int chg_seen, lat;
  initial begin
    rst_clk_tx = 1'b1;
    lb_sel_i = 2'b00;
    txd_tx = 2'b11;
    rxd_i = 2'b11;
    tbl[0] = '{2,  1'b1, 2'b00, 2'b11, 2'b11, 2'b00, 2'b00, 2'b11};
    tbl[1] = '{11, 1'b0, 2'b01, 2'b11, 2'b11, 2'b00, 2'b00, 2'b11};
    tbl[2] = '{1,  1'b0, 2'b01, 2'b11, 2'b11, 2'b01, 2'b01, 2'b11};
    tbl[3] = '{3,  1'b0, 2'b01, 2'b11, 2'b10, 2'b01, 2'b00, 2'b10};
    tbl[4] = '{2,  1'b0, 2'b01, 2'b01, 2'b11, 2'b01, 2'b00, 2'b01};
    tbl[5] = '{1,  1'b1, 2'b01, 2'b01, 2'b10, 2'b00, 2'b00, 2'b01};
    for (int v = 0; v < 6; v++) begin
      for (int k = 0; k < tbl[v].n; k++) begin
        rst_clk_tx = tbl[v].rst;
        lb_sel_i = tbl[v].sel;
        txd_tx = tbl[v].txd;
        rxd_i = tbl[v].rxd;
        tick();
        chk($sformatf("vec%0d_active", v), lb_active_o, tbl[v].act);
        chk($sformatf("vec%0d_chg", v), lb_chg_o, tbl[v].chg);
        chk($sformatf("vec%0d_txd", v), txd_o, tbl[v].txo);
      end
    end
    txd_tx = 2'b11;
    rxd_i = 2'b11;
    lb_sel_i = 2'b00;
    do_reset();
    chg_seen = 0;
    for (int r = 0; r < 6; r++) begin
      lb_sel_i = 2'b01;
      repeat (5) begin tick(); chg_seen += lb_chg_o[0] + lb_active_o[0]; end
      lb_sel_i = 2'b00;
      repeat (3) begin tick(); chg_seen += lb_chg_o[0] + lb_active_o[0]; end
    end
    chk("bounce_quiet", 2'(chg_seen), 2'd0);
    lb_sel_i = 2'b01;
    for (int k = 0; k < 40; k++) begin
      txd_tx = {1'b1, 1'(k[1])};
      tick();
    end
    chk("toggle_hold", lb_active_o, 2'b00);
    txd_tx = 2'b11;
    chg_seen = 0;
    repeat (20) begin tick(); chg_seen += lb_chg_o[0]; end
    chk("toggle_pulses", 2'(chg_seen), 2'd1);
    chk("toggle_switched", lb_active_o, 2'b01);
    txd_tx = 2'b10;
    rxd_i = 2'b01;
    rst_clk_tx = 1'b1;
    tick();
    rst_clk_tx = 1'b0;
    chk("rst_active", lb_active_o, 2'b00);
    chk("rst_chg", lb_chg_o, 2'b00);
    chk("rst_txd", txd_o, 2'b10);
    txd_tx = 2'b11;
    rxd_i = 2'b11;
    lat = 0;
    while (!lb_active_o[0] && lat < 40) begin tick(); lat++; end
    chk("reentry_latency", 2'(lat == 12), 2'd1);
    lb_sel_i = 2'b00;
    do_reset();
    lb_sel_i = 2'b01;
    txd_tx = 2'b10;
    chg_seen = 0;
    repeat (15) begin tick(); chg_seen += lb_chg_o[0] + lb_active_o[0]; end
    lb_sel_i = 2'b00;
    repeat (20) begin tick(); chg_seen += lb_chg_o[0] + lb_active_o[0]; end
    txd_tx = 2'b11;
    repeat (10) begin tick(); chg_seen += lb_chg_o[0] + lb_active_o[0]; end
    chk("abort_quiet", 2'(chg_seen), 2'd0);
    do_reset();
    for (int k = 0; k < 4000; k++) begin
      rst_clk_tx = ($urandom_range(0, 599) == 0);
      for (int c = 0; c < 2; c++) begin
        if ($urandom_range(0, 59) == 0) lb_sel_i[c] = ~lb_sel_i[c];
        txd_tx[c] = ($urandom_range(0, 9) != 0) | (($urandom_range(0, 3) != 0) & txd_tx[c]);
        rxd_i[c] = $urandom_range(0, 7) != 0;
      end
      tick();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
